byte_stream_loader: RTL and testbench

- Front-end of the program-load path: accepts a framed byte stream over a valid/ready handshake (from a UART/debug bridge).
- Parses a small header, assembles little-endian 32-bit words and emits them as one-cycle write pulses on load_en/load_addr/load_data.
- These outputs drive the core top-level's load port, which feeds the loader and instruction ROM.
- Provides status (busy/done/err) so the testbench or SoC holds the core idle until loading completes.

---
 rtl/loader_pkg.sv | 24 ++
 rtl/byte_stream_loader_if.sv | 12 +
 rtl/word_assembler.sv | 44 ++++
 rtl/byte_stream_loader.sv | 147 ++++++++++++++
 tb/tb_byte_stream_loader.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the byte-stream program loader: state encoding,
// frame start byte and header field sizes.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_ADDR = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  // Address, length and data words are all 4-byte little-endian fields.
  localparam int unsigned FIELD_BYTES = 4;
  localparam int unsigned LANE_W      = $clog2(FIELD_BYTES);

  function automatic logic in_frame(input state_t s);
    return (s == ST_ADDR) || (s == ST_LEN) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/byte_stream_loader_if.sv
// Byte stream valid/ready handshake; the master drives bytes, the loader
// (slave) returns in_ready.
interface byte_stream_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/word_assembler.sv
// Collects four accepted bytes LSB-first into a 32-bit word; word_valid is
// high combinationally in the cycle the fourth byte is presented.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [23:0]       shift_q, shift_d;

  // Only the three earlier bytes are stored; the top byte comes straight
  // from the input so the word is ready in the lane-3 acceptance cycle.
  assign word_valid = byte_valid && (lane_q == LANE_W'(FIELD_BYTES - 1));
  assign word       = {byte_in, shift_q};

  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clear) begin
      lane_d = '0;
    end else if (byte_valid) begin
      lane_d  = lane_q + 1'b1;
      shift_d = {byte_in, shift_q[23:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/byte_stream_loader.sv
// Program-load front end: parses MAGIC/ADDR/LEN framed byte streams and
// emits one-cycle word writes on the load port, with busy/done/err status.
module byte_stream_loader
  import loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [7:0]  MAGIC          = MAGIC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  byte_stream_loader_if.slave  in_if,
  input  logic                 restart,
  output logic                 load_en,
  output logic [31:0]          load_addr,
  output logic [31:0]          load_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state_q, state_d;
  logic [31:0]       base_q, base_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       idx_q, idx_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              load_en_q, load_en_d;
  logic [31:0]       load_addr_q, load_addr_d;
  logic [31:0]       load_data_q, load_data_d;

  logic        in_ready;
  logic        accept;
  logic        field_valid;
  logic        word_valid;
  logic [31:0] word;
  logic        asm_clear;

  assign in_ready       = (state_q != ST_DONE) && (state_q != ST_ERR);
  assign in_if.in_ready = in_ready;
  assign accept         = in_if.in_valid && in_ready;
  assign field_valid    = accept && in_frame(state_q);
  assign asm_clear      = (state_d != state_q);

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_valid (field_valid),
    .byte_in    (in_if.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Next-state and datapath; every field transition fires only on an
  // accepted byte, so it never collides with the idle timeout.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    idle_d      = idle_q;
    load_en_d   = 1'b0;
    load_addr_d = load_addr_q;
    load_data_d = load_data_q;

    if (in_frame(state_q)) begin
      if (accept) begin
        idle_d = '0;
      end else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        idle_d  = '0;
        state_d = ST_ERR;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end

    case (state_q)
      ST_SYNC: begin
        if (accept && (in_if.in_data == MAGIC)) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (word_valid) begin
          base_d  = word;
          state_d = (word[1:0] != 2'b00) ? ST_ERR : ST_LEN;
        end
      end
      ST_LEN: begin
        if (word_valid) begin
          len_d = word;
          idx_d = '0;
          if (word == 32'd0)                 state_d = ST_DONE;
          else if (word > 32'(MAX_WORDS))    state_d = ST_ERR;
          else                               state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_valid) begin
          load_en_d   = 1'b1;
          load_addr_d = base_q + {idx_q[29:0], 2'b00};
          load_data_d = word;
          idx_d       = idx_q + 32'd1;
          if (idx_q == len_q - 32'd1) state_d = ST_DONE;
        end
      end
      ST_DONE, ST_ERR: begin
        if (restart) begin
          state_d = ST_SYNC;
          idx_d   = '0;
          idle_d  = '0;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      idle_q      <= '0;
      load_en_q   <= 1'b0;
      load_addr_q <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      idle_q      <= idle_d;
      load_en_q   <= load_en_d;
      load_addr_q <= load_addr_d;
      load_data_q <= load_data_d;
    end
  end

  assign load_en   = load_en_q;
  assign load_addr = load_addr_q;
  assign load_data = load_data_q;
  assign busy      = in_frame(state_q);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERR);

endmodule

// File: tb/tb_byte_stream_loader.sv
// Self-checking bench for byte_stream_loader: directed header/error/timeout
// cases plus random frames, compared against a queue-based write model.
module tb_byte_stream_loader;

  localparam int unsigned TB_MAX_WORDS = 4096;
  localparam int unsigned TB_TIMEOUT   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        restart;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        busy;
  logic        done;
  logic        err;

  byte_stream_loader_if bus ();

  byte_stream_loader #(
    .MAX_WORDS      (TB_MAX_WORDS),
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .MAGIC          (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_if     (bus),
    .restart   (restart),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int inv_viol = 0;

  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic        last_pulse_done = 1'b0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  frame_q[$];
  logic [31:0] words_q[$];

  // Observed write log, sampled on the falling edge.
  always @(negedge clk) begin
    if (load_en) begin
      obs_addr.push_back(load_addr);
      obs_data.push_back(load_data);
      last_pulse_done = done;
    end
    if (done && err) inv_viol++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) frame_q.push_back(w[8*b +: 8]);
  endtask

  // Reference model: frame bytes and, for good frames, writes at base+4*i.
  task automatic model_frame(input logic [31:0] base, input logic [31:0] len, input bit expect_writes);
    frame_q = {};
    frame_q.push_back(8'hA5);
    push_word(base);
    push_word(len);
    for (int i = 0; i < words_q.size(); i++) begin
      push_word(words_q[i]);
      if (expect_writes) begin
        exp_addr.push_back(base + 32'(i * 4));
        exp_data.push_back(words_q[i]);
      end
    end
  endtask

  task automatic apply_stimulus(input int from, input int to, input int max_gap);
    for (int i = from; i < to; i++) begin
      send_byte(frame_q[i]);
      if (max_gap > 0 && i < to - 1) tick($urandom_range(0, max_gap));
    end
  endtask

  task automatic check_status(input string tag, input logic e_busy, input logic e_done,
                              input logic e_err, input logic e_ready);
    check({tag, "_busy"},  32'(busy),         32'(e_busy));
    check({tag, "_done"},  32'(done),         32'(e_done));
    check({tag, "_err"},   32'(err),          32'(e_err));
    check({tag, "_ready"}, 32'(bus.in_ready), 32'(e_ready));
  endtask

  task automatic check_output(input string tag);
    int n;
    check({tag, "_count"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, obs_addr[i], exp_addr[i]);
      check({tag, "_data"}, obs_data[i], exp_data[i]);
    end
    obs_addr = {};
    obs_data = {};
    exp_addr = {};
    exp_data = {};
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (!(done || err) && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_ended"}, 32'(done || err), 32'd1);
  endtask

  task automatic do_restart(input string tag);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    check_status({tag, "_restart"}, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] base;
    int          len;
    logic [7:0]  junk;

    rst          = 1'b1;
    restart      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    tick(2);
    rst = 1'b0;
    check_status("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_load_en", 32'(load_en), 32'd0);
    check("reset_load_addr", load_addr, 32'd0);

    // Nominal frame with leading junk bytes, all back-to-back.
    words_q = '{32'h0000_0013, 32'h0050_0093};
    model_frame(32'h8000_0100, 32'd2, 1'b1);
    send_byte(8'h12);
    send_byte(8'h00);
    apply_stimulus(0, frame_q.size(), 0);
    check("nom_final_load_en", 32'(load_en), 32'd1);
    check_status("nom", 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    check("nom_last_pulse_done", 32'(last_pulse_done), 32'd1);
    check("nom_hold_addr", load_addr, 32'h8000_0104);
    check("nom_load_en_low", 32'(load_en), 32'd0);
    check_output("nom");
    do_restart("nom");

    // Misaligned base address.
    words_q = {};
    model_frame(32'h8000_0002, 32'd1, 1'b0);
    apply_stimulus(0, 5, 0);
    check_status("misalign", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2);
    check_output("misalign");
    do_restart("misalign");

    // Length just above the limit.
    model_frame(32'h0000_0040, 32'(TB_MAX_WORDS + 1), 1'b0);
    apply_stimulus(0, frame_q.size(), 0);
    check_status("toolong", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2);
    check_output("toolong");
    do_restart("toolong");

    // Zero-length frame completes straight after LEN.
    model_frame(32'h0000_0040, 32'd0, 1'b0);
    apply_stimulus(0, frame_q.size(), 0);
    check_status("zerolen", 1'b0, 1'b1, 1'b0, 1'b0);
    tick(2);
    check_output("zerolen");
    do_restart("zerolen");

    // Stall of TIMEOUT idle cycles after the second data byte aborts.
    words_q = '{32'hDEAD_BEEF, 32'h1234_5678};
    model_frame(32'h0000_1000, 32'd2, 1'b0);
    apply_stimulus(0, 11, 0);
    tick(TB_TIMEOUT);
    check_status("timeout", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(2);
    check_output("timeout");
    do_restart("timeout");

    // Stall of TIMEOUT-1 idle cycles survives.
    model_frame(32'h0000_1000, 32'd2, 1'b1);
    apply_stimulus(0, 11, 0);
    tick(TB_TIMEOUT - 1);
    check_status("stall_ok_mid", 1'b1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(11, frame_q.size(), 0);
    check_status("stall_ok", 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_output("stall_ok");
    do_restart("stall_ok");

    // Address wrap at the top of the address space.
    words_q = '{32'hAAAA_5555, 32'h0F0F_F0F0};
    model_frame(32'hFFFF_FFFC, 32'd2, 1'b1);
    apply_stimulus(0, frame_q.size(), 0);
    check_status("wrap", 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_output("wrap");
    do_restart("wrap");

    // Reset on the edge that accepts lane 3 suppresses the write.
    words_q = '{32'h1111_2222};
    model_frame(32'h0000_2000, 32'd1, 1'b0);
    apply_stimulus(0, 12, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = frame_q[12];
    rst          = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_lane3_load_en", 32'(load_en), 32'd0);
    check_status("rst_lane3", 1'b0, 1'b0, 1'b0, 1'b1);
    tick(2);
    check_output("rst_lane3");

    // Restart pulsed mid-DATA has no effect.
    words_q = '{32'hCAFE_F00D, 32'h0BAD_C0DE};
    model_frame(32'h0000_3000, 32'd2, 1'b1);
    apply_stimulus(0, 12, 0);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    check_status("restart_data", 1'b1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(12, frame_q.size(), 0);
    check_status("restart_data_end", 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_output("restart_data");
    do_restart("restart_data");

    // Random frames with random junk prefixes and inter-byte gaps.
    for (int f = 0; f < 6; f++) begin
      base = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
      len  = $urandom_range(1, 5);
      words_q = {};
      for (int i = 0; i < len; i++) words_q.push_back($urandom());
      model_frame(base, 32'(len), 1'b1);
      for (int j = 0; j < $urandom_range(0, 3); j++) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk);
      end
      apply_stimulus(0, frame_q.size(), TB_TIMEOUT - 2);
      wait_end("rand", 20);
      check_status("rand", 1'b0, 1'b1, 1'b0, 1'b0);
      tick(1);
      check_output("rand");
      do_restart("rand");
    end

    check("invariant_done_err", 32'(inv_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
